// File: rtl/sha256_msg_scheduler_pkg.sv
// Shared definitions for the SHA-256 message scheduler: block/round constants,
// FSM state encoding and the small-sigma helper functions.
package sha256_msg_scheduler_pkg;

   localparam int unsigned BLOCK_WORDS = 16;
   localparam int unsigned NUM_ROUNDS  = 64;

   localparam logic [3:0] LAST_LOAD  = 4'(BLOCK_WORDS - 1);
   localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_EMIT,
      ST_DONE
   } sched_state_e;

   function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_msg_scheduler_new_w.sv
// Combinational SHA-256 schedule word: sigma1(b) + d + sigma0(a) + c, mod 2^32.
// a=W[t-15], b=W[t-2], c=W[t-16], d=W[t-7].
module SHA256_New_W
   import sha256_msg_scheduler_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] c,
   input  logic [31:0] d,
   output logic [31:0] w
);

   always_comb begin
      w = sigma1(b) + d + sigma0(a) + c;
   end

endmodule

// File: rtl/sha256_msg_scheduler.sv
// SHA-256 message scheduler: loads 16 message words into a flop-based circular
// buffer, then streams W0..W63 over a valid/ready handshake.
module sha256_msg_scheduler
   import sha256_msg_scheduler_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        load_valid,
   input  logic [31:0] load_data,
   output logic        load_ready,
   output logic        w_valid,
   input  logic        w_ready,
   output logic [31:0] w_out,
   output logic [5:0]  w_index,
   output logic        busy,
   output logic        done
);

   sched_state_e state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [31:0]  w_out_q, w_out_d;
   logic [5:0]   idx_q, idx_d;

   logic [31:0]  buf_q [BLOCK_WORDS];
   logic         buf_we;
   logic [3:0]   buf_waddr;
   logic [31:0]  buf_wdata;

   logic [5:0]   idx_nxt;
   logic [3:0]   slot_t, slot_m2, slot_m7, slot_m15;
   logic [31:0]  new_w;

   // Slot offsets are taken mod 16: t-2 = t+14, t-7 = t+9, t-15 = t+1, t-16 = t.
   assign idx_nxt  = idx_q + 6'd1;
   assign slot_t   = idx_nxt[3:0];
   assign slot_m2  = slot_t + 4'd14;
   assign slot_m7  = slot_t + 4'd9;
   assign slot_m15 = slot_t + 4'd1;

   SHA256_New_W u_new_w (
      .a (buf_q[slot_m15]),
      .b (buf_q[slot_m2]),
      .c (buf_q[slot_t]),
      .d (buf_q[slot_m7]),
      .w (new_w)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      w_out_d   = w_out_q;
      idx_d     = idx_q;
      buf_we    = 1'b0;
      buf_waddr = cnt_q;
      buf_wdata = load_data;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end
         end
         ST_LOAD: begin
            if (load_valid) begin
               buf_we    = 1'b1;
               buf_waddr = cnt_q;
               buf_wdata = load_data;
               cnt_d     = cnt_q + 4'd1;
               // W0 was written on the first accept, so it can be presented on EMIT entry.
               if (cnt_q == LAST_LOAD) begin
                  state_d = ST_EMIT;
                  idx_d   = '0;
                  w_out_d = buf_q[0];
               end
            end
         end
         ST_EMIT: begin
            if (w_ready) begin
               if (idx_q == LAST_ROUND) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d = idx_nxt;
                  if (idx_nxt[5:4] == 2'b00) begin
                     w_out_d = buf_q[slot_t];
                  end else begin
                     // Slot t is read as W[t-16] and replaced by W[t] on the same edge.
                     w_out_d   = new_w;
                     buf_we    = 1'b1;
                     buf_waddr = slot_t;
                     buf_wdata = new_w;
                  end
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         w_out_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         w_out_q <= w_out_d;
         idx_q   <= idx_d;
      end
   end

   always_ff @(posedge clk) begin
      if (buf_we) begin
         buf_q[buf_waddr] <= buf_wdata;
      end
   end

   assign load_ready = (state_q == ST_LOAD);
   assign w_valid    = (state_q == ST_EMIT);
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE);
   assign w_out      = w_out_q;
   assign w_index    = idx_q;

endmodule

// File: tb/tb_sha256_msg_scheduler.sv
// Directed bench for sha256_msg_scheduler: abc block, stalls, load gaps,
// mid-block reset, ignored start/load during EMIT and back-to-back blocks.
module tb_sha256_msg_scheduler;

   typedef logic [31:0] blk_t   [16];
   typedef logic [31:0] sched_t [64];

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        load_valid;
   logic [31:0] load_data;
   logic        load_ready;
   logic        w_valid;
   logic        w_ready;
   logic [31:0] w_out;
   logic [5:0]  w_index;
   logic        busy;
   logic        done;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   always #5 clk = ~clk;

   sha256_msg_scheduler dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .w_valid    (w_valid),
      .w_ready    (w_ready),
      .w_out      (w_out),
      .w_index    (w_index),
      .busy       (busy),
      .done       (done)
   );

   function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic golden(input blk_t m, output sched_t w);
      sched_t g;
      for (int t = 0; t < 64; t++) begin
         if (t < 16) g[t] = m[t];
         else g[t] = (ror(g[t-2], 17) ^ ror(g[t-2], 19) ^ (g[t-2] >> 10)) + g[t-7]
                   + (ror(g[t-15], 7) ^ ror(g[t-15], 18) ^ (g[t-15] >> 3)) + g[t-16];
      end
      w = g;
   endtask

   task automatic abc_block(output blk_t m);
      for (int i = 0; i < 16; i++) m[i] = 32'h0;
      m[0]  = 32'h61626380;
      m[15] = 32'h00000018;
   endtask

   task automatic rand_block(output blk_t m);
      for (int i = 0; i < 16; i++) m[i] = $urandom;
   endtask

   // Entered at a negedge while IDLE; leaves at the negedge after the 16th accept.
   task automatic do_load(input blk_t m, input bit gaps);
      int unsigned n = 0;
      int unsigned cyc = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (n < 16 && cyc < 100) begin
         n_total++;
         if (load_ready !== 1'b1 || w_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL load_state n=%0d got ready=%b valid=%b busy=%b exp 1 0 1",
                     n, load_ready, w_valid, busy);
         else n_pass++;
         load_valid = gaps ? ((cyc % 2) == 0) : 1'b1;
         load_data  = load_valid ? m[n] : $urandom;
         if (load_valid) n++;
         @(negedge clk);
         cyc++;
      end
      load_valid = 1'b0;
      load_data  = $urandom;
      n_total++;
      if (n != 16) $display("FAIL load_timeout accepted %0d exp 16", n);
      else n_pass++;
   endtask

   task automatic do_emit(input blk_t m, input bit stall, input bit poke,
                          input int unsigned stop_at, output sched_t obs);
      sched_t exp;
      int unsigned t = 0;
      int unsigned cyc = 0;
      golden(m, exp);
      while (t < stop_at && cyc < 1000) begin
         n_total++;
         if (w_valid !== 1'b1 || w_index !== 6'(t) || w_out !== exp[t] || done !== 1'b0)
            $display("FAIL emit_word t=%0d got valid=%b idx=%0d out=%h done=%b exp 1 %0d %h 0",
                     t, w_valid, w_index, w_out, done, t, exp[t]);
         else n_pass++;
         obs[t] = w_out;
         if (poke) begin
            start      = ($urandom_range(0, 1) == 1);
            load_valid = 1'b1;
            load_data  = $urandom;
            n_total++;
            if (load_ready !== 1'b0) $display("FAIL poke_load_ready got %b exp 0", load_ready);
            else n_pass++;
         end
         w_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (w_ready) t++;
         @(negedge clk);
         cyc++;
      end
      w_ready    = 1'b0;
      start      = 1'b0;
      load_valid = 1'b0;
      n_total++;
      if (t != stop_at) $display("FAIL emit_timeout reached t=%0d exp %0d", t, stop_at);
      else n_pass++;
      if (stop_at == 64) begin
         n_total++;
         if (done !== 1'b1 || w_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL done_pulse got done=%b valid=%b busy=%b exp 1 0 1", done, w_valid, busy);
         else n_pass++;
         @(negedge clk);
         n_total++;
         if (done !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b0 || w_valid !== 1'b0)
            $display("FAIL done_idle got done=%b busy=%b ready=%b valid=%b exp 0 0 0 0",
                     done, busy, load_ready, w_valid);
         else n_pass++;
      end
   endtask

   task automatic test_reset;
      reset      = 1'b1;
      start      = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      w_ready    = 1'b0;
      repeat (2) @(negedge clk);
      n_total++;
      if ({load_ready, w_valid, busy, done} !== 4'b0000 || w_out !== 32'h0 || w_index !== 6'd0)
         $display("FAIL reset_values got ready=%b valid=%b busy=%b done=%b out=%h idx=%0d exp all 0",
                  load_ready, w_valid, busy, done, w_out, w_index);
      else n_pass++;
      reset = 1'b0;
      @(negedge clk);
      n_total++;
      if (busy !== 1'b0 || load_ready !== 1'b0) $display("FAIL reset_idle got busy=%b ready=%b exp 0 0", busy, load_ready);
      else n_pass++;
   endtask

   task automatic test_abc;
      blk_t m;
      sched_t obs;
      abc_block(m);
      do_load(m, 1'b0);
      do_emit(m, 1'b0, 1'b0, 64, obs);
      n_total++;
      if (obs[16] !== 32'h61626380) $display("FAIL abc_w16 got %h exp 61626380", obs[16]);
      else n_pass++;
      n_total++;
      if (obs[17] !== 32'h000F0000) $display("FAIL abc_w17 got %h exp 000f0000", obs[17]);
      else n_pass++;
      n_total++;
      if (obs[18] !== 32'h7DA86405) $display("FAIL abc_w18 got %h exp 7da86405", obs[18]);
      else n_pass++;
   endtask

   task automatic test_stall;
      blk_t m;
      sched_t obs;
      abc_block(m);
      do_load(m, 1'b0);
      do_emit(m, 1'b1, 1'b0, 64, obs);
   endtask

   task automatic test_load_gaps;
      blk_t m;
      sched_t obs;
      rand_block(m);
      do_load(m, 1'b1);
      do_emit(m, 1'b0, 1'b0, 64, obs);
   endtask

   task automatic test_ignore_inputs;
      blk_t m;
      sched_t obs;
      rand_block(m);
      do_load(m, 1'b0);
      do_emit(m, 1'b1, 1'b1, 64, obs);
   endtask

   task automatic test_reset_mid;
      blk_t m;
      sched_t obs;
      rand_block(m);
      do_load(m, 1'b0);
      do_emit(m, 1'b0, 1'b0, 30, obs);
      n_total++;
      if (w_index !== 6'd30) $display("FAIL abort_point got idx=%0d exp 30", w_index);
      else n_pass++;
      reset = 1'b1;
      #1;
      n_total++;
      if ({load_ready, w_valid, busy, done} !== 4'b0000 || w_out !== 32'h0 || w_index !== 6'd0)
         $display("FAIL abort_reset got ready=%b valid=%b busy=%b done=%b out=%h idx=%0d exp all 0",
                  load_ready, w_valid, busy, done, w_out, w_index);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         load_valid = 1'b1;
         load_data  = $urandom;
         @(negedge clk);
         n_total++;
         if (busy !== 1'b0 || load_ready !== 1'b0 || w_valid !== 1'b0)
            $display("FAIL no_start_idle got busy=%b ready=%b valid=%b exp 0 0 0", busy, load_ready, w_valid);
         else n_pass++;
      end
      load_valid = 1'b0;
      rand_block(m);
      do_load(m, 1'b0);
      do_emit(m, 1'b0, 1'b0, 64, obs);
   endtask

   task automatic test_back_to_back;
      blk_t a;
      blk_t b;
      sched_t obs;
      rand_block(a);
      rand_block(b);
      do_load(a, 1'b0);
      do_emit(a, 1'b0, 1'b0, 64, obs);
      do_load(b, 1'b0);
      do_emit(b, 1'b0, 1'b0, 64, obs);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_abc();
      test_stall();
      test_load_gaps();
      test_ignore_inputs();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sha256_msg_scheduler.md
SHA256_MSG_SCHEDULER -- requirements
Module: sha256_msg_scheduler

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: start  in  1  begin a new 512-bit block; sampled only in IDLE.
REQ-004 SHALL have ports: load_valid  in  1  load_data holds a message word.
REQ-005 SHALL have ports: load_data  in  32  message word, big-endian order, W0 first.
REQ-006 SHALL have ports: load_ready  out  1  scheduler accepts a word this cycle.
REQ-007 SHALL have ports: w_valid  out  1  w_out/w_index hold a valid schedule word.
REQ-008 SHALL have ports: w_ready  in  1  round logic consumes w_out this cycle.
REQ-009 SHALL have ports: w_out  out  32  schedule word W[t].
REQ-010 SHALL have ports: w_index  out  6  t, 0..63.
REQ-011 SHALL have ports: busy  out  1  high in any state other than IDLE.
REQ-012 SHALL have ports: done  out  1  one-cycle pulse after W63 is consumed.

Function
REQ-013 SHALL implement FSM IDLE -> LOAD -> EMIT -> DONE -> IDLE.
REQ-014 IDLE: load_ready=0, w_valid=0; start=1 -> LOAD, word counter cleared.
REQ-015 LOAD: load_ready=1; each load_valid&load_ready writes load_data into buffer slot count[3:0]; 16th accept -> EMIT.
REQ-016 SHALL hold a 16x32 circular buffer; slot for W[t] is t mod 16.
REQ-017 On EMIT entry (cycle after 16th accept) w_out SHALL equal W0, w_index=0, w_valid=1.
REQ-018 w_out/w_index SHALL be registered and held stable while w_valid=1 and w_ready=0.
REQ-019 On w_valid&w_ready with w_index=t<63: next t'=t+1; t'<16 -> w_out=buf[t']; t'>=16 -> w_out=newW(t'), also written to slot t' mod 16.
REQ-020 newW(t) SHALL equal sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], modulo 2^32, read from slots (t-2),(t-7),(t-15),(t-16) mod 16.
REQ-021 Slot t mod 16 SHALL be read (as W[t-16]) and overwritten (as W[t]) in the same cycle; the read uses the pre-write value.
REQ-022 Handshake at w_index=63 SHALL move to DONE; w_valid=0 in DONE.
REQ-023 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-024 Throughput SHALL be one W word per cycle when w_ready is held high; the full block takes 16 load + 64 emit + 1 done cycles minimum.
REQ-025 start outside IDLE SHALL be ignored; load_valid outside LOAD SHALL be ignored (load_ready=0).
REQ-026 Gaps in load_valid or w_ready SHALL stall without losing or duplicating words.

Reset
REQ-027 reset SHALL force IDLE immediately, regardless of state, aborting any block in progress.
REQ-028 Reset values: load_ready=0, w_valid=0, w_out=0, w_index=0, busy=0, done=0, counter=0; buffer contents are don't-care.
REQ-029 After reset deasserts, the next block SHALL require a fresh start and 16 new words.

Structure
REQ-030 FSM state enum and constants (16-word block, 64 rounds) SHALL live in the shared Definitions package.
REQ-031 newW computation SHALL instantiate the existing SHA256_New_W combinational block (a=W[t-15], b=W[t-2], c=W[t-16], d=W[t-7]); no other sub-module.
REQ-032 Buffer SHALL be flops (no RAM inference) so four reads and one write occur per cycle.

Verification
REQ-033 "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> W16=0x61626380, W17=0x000F0000, W18=0x7DA86405; W0..W63 match the golden model.
REQ-034 Random w_ready deassertion over the same block -> identical 64-word sequence, w_out stable while stalled, done once.
REQ-035 load_valid toggled 50% during LOAD -> exactly 16 words stored, EMIT starts the cycle after the 16th accept.
REQ-036 reset asserted at w_index=30 -> same-edge IDLE, all outputs at reset values; a new block afterwards matches the golden model.
REQ-037 start pulsed during EMIT and load_valid held high during EMIT -> no effect on sequence, load_ready stays 0.
REQ-038 Two back-to-back blocks (start in the IDLE cycle after done) -> second block schedule is independent of the first.
